// File: rtl/neuron_spike_writeback.sv
// Potential write-back register file plus spike FIFO for the neuron update pipeline.
// Handles the end-of-timestep drain and raises a one-cycle completion pulse.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_RUN   | accepting updates; tick_done_i starts the drain
// ST_DRAIN | no new updates; FIFO drains, then tick_done_o pulses
module neuron_spike_writeback #(
    parameter int NUM_NEURONS = 16,
    parameter int IDX_W       = 4,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [IDX_W-1:0] neuron_idx_i,
    input  logic [7:0]       new_potential_i,
    input  logic             spike_i,
    input  logic             tick_done_i,
    input  logic [IDX_W-1:0] rd_idx_i,
    output logic [7:0]       rd_potential_o,
    output logic             spike_valid_o,
    input  logic             spike_ready_i,
    output logic [IDX_W-1:0] spike_idx_o,
    output logic [7:0]       spike_count_o,
    output logic             tick_done_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [0:0] ST_RUN   = 1'b0;
    localparam logic [0:0] ST_DRAIN = 1'b1;
    localparam logic [IDX_W:0] NUM_N    = (IDX_W + 1)'(NUM_NEURONS);
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(FIFO_DEPTH);

    logic [0:0]       state;
    logic [7:0]       pot_mem  [NUM_NEURONS];
    logic [IDX_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   fifo_cnt, fifo_cnt_next;
    logic             fifo_empty, fifo_full, accept, in_range, push, pop;

    assign fifo_empty    = (fifo_cnt == '0);
    assign fifo_full     = (fifo_cnt == FULL_CNT);
    assign in_ready_o    = (state == ST_RUN) && !fifo_full;
    assign accept        = in_valid_i && in_ready_o;
    assign in_range      = ({1'b0, neuron_idx_i} < NUM_N);
    assign push          = accept && in_range && spike_i;
    assign spike_valid_o = !fifo_empty;
    assign spike_idx_o   = fifo_empty ? '0 : fifo_mem[rd_ptr];
    assign pop           = spike_valid_o && spike_ready_i;
    assign fifo_cnt_next = fifo_cnt + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

    // Out-of-range read addresses fall through to the zero default.
    always_comb begin
        rd_potential_o = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            if (rd_idx_i == IDX_W'(i)) rd_potential_o = pot_mem[i];
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_NEURONS; i++) pot_mem[i] <= '0;
        end else if (accept && in_range) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                if (neuron_idx_i == IDX_W'(i)) pot_mem[i] <= new_potential_i;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= ST_RUN;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_cnt      <= '0;
            spike_count_o <= '0;
            tick_done_o   <= 1'b0;
        end else begin
            tick_done_o <= 1'b0;
            fifo_cnt    <= fifo_cnt_next;
            if (push) begin
                fifo_mem[wr_ptr] <= neuron_idx_i;
                wr_ptr           <= wr_ptr + 1'b1;
                if (spike_count_o != 8'hFF) spike_count_o <= spike_count_o + 8'd1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case (state)
                ST_RUN: begin
                    if (tick_done_i) state <= ST_DRAIN;
                end
                default: begin
                    // Done once the FIFO will be empty after this edge.
                    if (fifo_cnt_next == '0) begin
                        state         <= ST_RUN;
                        tick_done_o   <= 1'b1;
                        spike_count_o <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_spike_writeback.sv
// Directed bench for neuron_spike_writeback (NUM_NEURONS=12, IDX_W=4, FIFO_DEPTH=8).
module tb_neuron_spike_writeback;
    logic       clk_i = 1'b0;
    logic       rst_i, in_valid_i, spike_i, tick_done_i, spike_ready_i;
    logic       in_ready_o, spike_valid_o, tick_done_o;
    logic [3:0] neuron_idx_i, rd_idx_i, spike_idx_o;
    logic [7:0] new_potential_i, rd_potential_o, spike_count_o;
    int n_pass = 0;
    int n_total = 0;

    neuron_spike_writeback #(.NUM_NEURONS(12), .IDX_W(4), .FIFO_DEPTH(8)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .neuron_idx_i(neuron_idx_i), .new_potential_i(new_potential_i), .spike_i(spike_i),
        .tick_done_i(tick_done_i), .rd_idx_i(rd_idx_i), .rd_potential_o(rd_potential_o),
        .spike_valid_o(spike_valid_o), .spike_ready_i(spike_ready_i), .spike_idx_o(spike_idx_o),
        .spike_count_o(spike_count_o), .tick_done_o(tick_done_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [3:0] idx, input logic [7:0] pot, input logic sp);
        in_valid_i = v;
        neuron_idx_i = idx;
        new_potential_i = pot;
        spike_i = sp;
    endtask

    initial begin
        rst_i = 1'b1; tick_done_i = 1'b0; spike_ready_i = 1'b0; rd_idx_i = 4'd3;
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        tick(); tick();
        rst_i = 1'b0;
        tick();
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        chk("rst_spike_valid", 32'(spike_valid_o), 32'd0);
        chk("rst_spike_idx", 32'(spike_idx_o), 32'd0);
        chk("rst_count", 32'(spike_count_o), 32'd0);
        chk("rst_tick_done", 32'(tick_done_o), 32'd0);
        chk("rst_pot3", 32'(rd_potential_o), 32'd0);

        // write idx 3 = 0x5A, no spike; no same-cycle bypass
        drive(1'b1, 4'd3, 8'h5A, 1'b0);
        #1 chk("no_bypass", 32'(rd_potential_o), 32'd0);
        tick();
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        chk("wr_pot3", 32'(rd_potential_o), 32'h5A);
        chk("wr_no_spike", 32'(spike_valid_o), 32'd0);
        chk("wr_count", 32'(spike_count_o), 32'd0);

        // boundary index 11 is the last valid entry
        drive(1'b1, 4'd11, 8'hC3, 1'b0); rd_idx_i = 4'd11;
        tick();
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        chk("wr_pot11", 32'(rd_potential_o), 32'hC3);

        // back-to-back spikes 1, 7, 2 with router ready
        spike_ready_i = 1'b1;
        drive(1'b1, 4'd1, 8'h11, 1'b1); tick();
        chk("b2b_v0", 32'(spike_valid_o), 32'd1);
        chk("b2b_idx0", 32'(spike_idx_o), 32'd1);
        drive(1'b1, 4'd7, 8'h77, 1'b1); tick();
        chk("b2b_idx1", 32'(spike_idx_o), 32'd7);
        drive(1'b1, 4'd2, 8'h22, 1'b1); tick();
        chk("b2b_idx2", 32'(spike_idx_o), 32'd2);
        drive(1'b0, 4'd0, 8'h00, 1'b0); tick();
        chk("b2b_empty", 32'(spike_valid_o), 32'd0);
        chk("b2b_count", 32'(spike_count_o), 32'd3);

        // fill the FIFO with idx 0..7 while the router stalls
        spike_ready_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 4'(i), 8'(i), 1'b1);
            #1 chk("fill_ready", 32'(in_ready_o), 32'd1);
            tick();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        chk("full_not_ready", 32'(in_ready_o), 32'd0);
        chk("full_head", 32'(spike_idx_o), 32'd0);
        chk("full_count", 32'(spike_count_o), 32'd11);
        tick();
        chk("stall_head", 32'(spike_idx_o), 32'd0);
        chk("stall_valid", 32'(spike_valid_o), 32'd1);
        spike_ready_i = 1'b1; tick(); spike_ready_i = 1'b0;
        chk("pop_ready", 32'(in_ready_o), 32'd1);
        chk("pop_head", 32'(spike_idx_o), 32'd1);

        // empty the remaining 7 entries
        spike_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        spike_ready_i = 1'b0;
        chk("flush_empty", 32'(spike_valid_o), 32'd0);

        // 3 queued spikes then end of timestep
        for (int i = 4; i < 7; i++) begin
            drive(1'b1, 4'(i), 8'h00, 1'b1); tick();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        chk("pre_drain_count", 32'(spike_count_o), 32'd14);
        tick_done_i = 1'b1; spike_ready_i = 1'b1; tick(); tick_done_i = 1'b0;
        chk("drain_ready0", 32'(in_ready_o), 32'd0);
        chk("drain_td0", 32'(tick_done_o), 32'd0);
        chk("drain_head0", 32'(spike_idx_o), 32'd5);
        tick();
        chk("drain_ready1", 32'(in_ready_o), 32'd0);
        chk("drain_td1", 32'(tick_done_o), 32'd0);
        chk("drain_head1", 32'(spike_idx_o), 32'd6);
        tick();
        chk("drain_td_pulse", 32'(tick_done_o), 32'd1);
        chk("drain_count_clr", 32'(spike_count_o), 32'd0);
        chk("drain_ready_back", 32'(in_ready_o), 32'd1);
        tick();
        chk("drain_td_once", 32'(tick_done_o), 32'd0);

        // drain with an empty FIFO
        tick_done_i = 1'b1; tick(); tick_done_i = 1'b0;
        chk("edrain_ready", 32'(in_ready_o), 32'd0);
        chk("edrain_td0", 32'(tick_done_o), 32'd0);
        tick();
        chk("edrain_td1", 32'(tick_done_o), 32'd1);
        chk("edrain_ready_back", 32'(in_ready_o), 32'd1);
        tick();
        chk("edrain_td2", 32'(tick_done_o), 32'd0);

        // out-of-range index is accepted and discarded
        spike_ready_i = 1'b0;
        drive(1'b1, 4'd15, 8'hEE, 1'b1); rd_idx_i = 4'd15;
        #1 chk("oor_ready", 32'(in_ready_o), 32'd1);
        tick();
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        chk("oor_no_push", 32'(spike_valid_o), 32'd0);
        chk("oor_count", 32'(spike_count_o), 32'd0);
        chk("oor_read", 32'(rd_potential_o), 32'd0);

        // spike count saturates at 255
        spike_ready_i = 1'b1;
        for (int i = 0; i < 260; i++) begin
            drive(1'b1, 4'd5, 8'h55, 1'b1); tick();
        end
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        chk("sat_count", 32'(spike_count_o), 32'd255);
        tick();
        chk("sat_empty", 32'(spike_valid_o), 32'd0);

        // reset in DRAIN with 2 spikes queued
        spike_ready_i = 1'b0;
        drive(1'b1, 4'd8, 8'h88, 1'b1); tick();
        drive(1'b1, 4'd9, 8'h99, 1'b1); tick();
        drive(1'b0, 4'd0, 8'h00, 1'b0);
        tick_done_i = 1'b1; tick(); tick_done_i = 1'b0;
        chk("rd_drain_ready", 32'(in_ready_o), 32'd0);
        chk("rd_drain_valid", 32'(spike_valid_o), 32'd1);
        rst_i = 1'b1; tick(); rst_i = 1'b0;
        chk("rd_valid", 32'(spike_valid_o), 32'd0);
        chk("rd_ready", 32'(in_ready_o), 32'd1);
        chk("rd_td", 32'(tick_done_o), 32'd0);
        chk("rd_count", 32'(spike_count_o), 32'd0);
        for (int i = 0; i < 12; i++) begin
            rd_idx_i = 4'(i);
            #1 chk("rd_pot_zero", 32'(rd_potential_o), 32'd0);
        end
        tick();
        chk("rd_td_after", 32'(tick_done_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
